uart_frame_checker: RTL and testbench

Parametrised successor of the single-word frame checker in the UART receive path. Sits between the RX deserialiser and the consumer. Strips and checks the parity bit for 5-8 data bits with even or odd parity. Buffers checked words with per-word error flags in a small show-ahead FIFO behind a valid/ready interface, and keeps saturating error statistics.

---
 rtl/uart_frame_checker.sv | 142 ++++++++++++++
 tb/tb_uart_frame_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_checker.sv
// UART RX frame checker: strips and checks parity, then buffers checked words in a show-ahead FIFO with saturating error statistics.
// Optional break detection (break_det output) is enabled by defining UART_CHK_BREAK_EN.
module uart_frame_checker #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [8:0]                    data_in,
   input  logic                          data_valid,
   input  logic                          frame_err_i,
   input  logic                          cfg_par_en,
   input  logic                          cfg_par_odd,
   input  logic [1:0]                    cfg_len,
   input  logic                          clr_cnt,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [7:0]                    out_data,
   output logic                          out_parity_err,
   output logic                          out_frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              parity_err_cnt,
   output logic [CNT_W-1:0]              frame_err_cnt,
   output logic [CNT_W-1:0]              overrun_cnt
`ifdef UART_CHK_BREAK_EN
   ,
   output logic                          break_det
`endif
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   logic [7:0]       chk_data;
   logic             chk_par;
   logic             par_err;
   logic             is_brk;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   logic [9:0]       mem_q [FIFO_DEPTH];
   logic [9:0]       head;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d;
   logic             ovr_q, ovr_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0] ocnt_q, ocnt_d;

   // Clear wins over the stored value but not over a coincident event, which lands as 1.
   function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic clr);
      if (clr) return {{(CNT_W-1){1'b0}}, inc};
      if (inc && (cur != '1)) return cur + CNT_W'(1);
      return cur;
   endfunction

   always_comb begin
      chk_data = '0;
      chk_par  = 1'b0;
      case (cfg_len)
         2'd0:    begin chk_data = {3'b000, data_in[4:0]}; chk_par = data_in[5]; end
         2'd1:    begin chk_data = {2'b00,  data_in[5:0]}; chk_par = data_in[6]; end
         2'd2:    begin chk_data = {1'b0,   data_in[6:0]}; chk_par = data_in[7]; end
         default: begin chk_data = data_in[7:0];           chk_par = data_in[8]; end
      endcase
      par_err = cfg_par_en & (chk_par != (^chk_data ^ cfg_par_odd));
   end

`ifdef UART_CHK_BREAK_EN
   assign is_brk = frame_err_i & ~chk_par & (chk_data == 8'h00);
`else
   assign is_brk = 1'b0;
`endif

   assign full = (level_q == FULL_LVL);
   assign pop  = out_valid & out_ready;
   assign push = data_valid & ~is_brk & (~full | pop);
   assign drop = data_valid & ~is_brk & full & ~pop;

   always_comb begin
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
      level_d = level_q;
      if (push && !pop)      level_d = level_q + (AW+1)'(1);
      else if (pop && !push) level_d = level_q - (AW+1)'(1);
      ovr_d  = clr_cnt ? drop : (ovr_q | drop);
      pcnt_d = cnt_upd(pcnt_q, push & par_err,     clr_cnt);
      fcnt_d = cnt_upd(fcnt_q, push & frame_err_i, clr_cnt);
      ocnt_d = cnt_upd(ocnt_q, drop,               clr_cnt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovr_q   <= 1'b0;
         pcnt_q  <= '0;
         fcnt_q  <= '0;
         ocnt_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovr_q   <= ovr_d;
         pcnt_q  <= pcnt_d;
         fcnt_q  <= fcnt_d;
         ocnt_q  <= ocnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {chk_data, par_err, frame_err_i};
   end

`ifdef UART_CHK_BREAK_EN
   logic brk_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) brk_q <= 1'b0;
      else      brk_q <= data_valid & is_brk;
   end
   assign break_det = brk_q;
`endif

   // Storage is not reset, so the head is masked whenever the FIFO is empty.
   assign head           = mem_q[rptr_q];
   assign out_valid      = (level_q != '0);
   assign out_data       = out_valid ? head[9:2] : 8'h00;
   assign out_parity_err = out_valid & head[1];
   assign out_frame_err  = out_valid & head[0];
   assign overrun        = ovr_q;
   assign fifo_level     = level_q;
   assign parity_err_cnt = pcnt_q;
   assign frame_err_cnt  = fcnt_q;
   assign overrun_cnt    = ocnt_q;

endmodule

// File: tb/tb_uart_frame_checker.sv
// Randomized scoreboard bench for uart_frame_checker; a posedge predictor queues expected words, a negedge monitor pops and compares.
module tb_uart_frame_checker;

   localparam int DEPTH = 4;
   localparam int CW    = 8;
   localparam int MAXC  = (1 << CW) - 1;
`ifdef UART_CHK_BREAK_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] data_in;
   logic       data_valid, frame_err_i, cfg_par_en, cfg_par_odd, clr_cnt, out_ready;
   logic [1:0] cfg_len;
   logic       out_valid, out_parity_err, out_frame_err, overrun;
   logic [7:0] out_data;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [CW-1:0] parity_err_cnt, frame_err_cnt, overrun_cnt;
`ifdef UART_CHK_BREAK_EN
   logic       break_det;
`endif

   uart_frame_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .frame_err_i(frame_err_i), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
      .cfg_len(cfg_len), .clr_cnt(clr_cnt), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_parity_err(out_parity_err),
      .out_frame_err(out_frame_err), .overrun(overrun), .fifo_level(fifo_level),
      .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt),
      .overrun_cnt(overrun_cnt)
`ifdef UART_CHK_BREAK_EN
      , .break_det(break_det)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t exp_q[$];
   int   mlevel, m_pcnt, m_fcnt, m_ocnt;
   bit   m_ovr, brk_exp;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int upd(input int c, input bit inc, input bit clr);
      if (clr) return inc ? 1 : 0;
      return (c + int'(inc) > MAXC) ? MAXC : c + int'(inc);
   endfunction

   // Reference model: frame rules applied with plain arithmetic on the inputs seen at each edge.
   int   p_L, p_dval, p_ones;
   bit   p_par, p_exp_par, p_pe, p_brk, p_pop, p_acc, p_drop;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         mlevel = 0; m_pcnt = 0; m_fcnt = 0; m_ocnt = 0; m_ovr = 0; brk_exp = 0;
      end else begin
         p_pop = (mlevel > 0) && out_ready;
         p_acc = 0; p_drop = 0; p_brk = 0; p_pe = 0; p_dval = 0;
         if (data_valid) begin
            p_L    = int'(cfg_len) + 5;
            p_dval = int'(data_in) % (1 << p_L);
            p_par  = data_in[p_L];
            p_ones = 0;
            for (int i = 0; i < p_L; i++) p_ones += (p_dval >> i) & 1;
            p_exp_par = ((p_ones % 2) == 1) ^ cfg_par_odd;
            p_pe  = cfg_par_en && (p_par != p_exp_par);
            p_brk = BRK_EN && frame_err_i && ((int'(data_in) % (1 << (p_L + 1))) == 0);
            if (!p_brk) begin
               if (mlevel < DEPTH || p_pop) p_acc = 1;
               else                         p_drop = 1;
            end
         end
         if (p_acc) exp_q.push_back('{d: p_dval[7:0], pe: p_pe, fe: frame_err_i});
         mlevel = mlevel + int'(p_acc) - int'(p_pop);
         m_pcnt = upd(m_pcnt, p_acc && p_pe, clr_cnt);
         m_fcnt = upd(m_fcnt, p_acc && frame_err_i, clr_cnt);
         m_ocnt = upd(m_ocnt, p_drop, clr_cnt);
         m_ovr  = clr_cnt ? p_drop : (m_ovr | p_drop);
         brk_exp = p_brk;
      end
   end

   exp_t m_e;
   always @(negedge clk) begin
      if (rst && chk_en) begin
         chk("out_valid", int'(out_valid), int'(mlevel != 0));
         chk("fifo_level", int'(fifo_level), mlevel);
         chk("overrun", int'(overrun), int'(m_ovr));
         chk("parity_err_cnt", int'(parity_err_cnt), m_pcnt);
         chk("frame_err_cnt", int'(frame_err_cnt), m_fcnt);
         chk("overrun_cnt", int'(overrun_cnt), m_ocnt);
`ifdef UART_CHK_BREAK_EN
         chk("break_det", int'(break_det), int'(brk_exp));
`endif
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL pop_unexpected: got word %0h, expected none (t=%0t)", out_data, $time);
            end else begin
               m_e = exp_q.pop_front();
               chk("out_data", int'(out_data), int'(m_e.d));
               chk("out_parity_err", int'(out_parity_err), int'(m_e.pe));
               chk("out_frame_err", int'(out_frame_err), int'(m_e.fe));
            end
         end else if (!out_valid) begin
            chk("empty_out_data", int'(out_data), 0);
            chk("empty_flags", int'({out_parity_err, out_frame_err}), 0);
         end
      end
   end

   task automatic step(input bit v, input logic [8:0] d, input bit fe, input bit pen,
                       input bit odd, input logic [1:0] len, input bit clr, input bit rdy);
      data_valid = v; data_in = d; frame_err_i = fe; cfg_par_en = pen;
      cfg_par_odd = odd; cfg_len = len; clr_cnt = clr; out_ready = rdy;
      @(posedge clk); #1;
   endtask

   task automatic idle(input bit rdy);
      step(0, 9'h000, 0, 0, 0, 2'd0, 0, rdy);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && mlevel > 0; i++) idle(1);
      chk("drain_timeout", mlevel, 0);
   endtask

   logic [8:0] rd;
   int lvl_before;

   initial begin
      rst = 0; data_in = '0; data_valid = 0; frame_err_i = 0; cfg_par_en = 0;
      cfg_par_odd = 0; cfg_len = 2'd0; clr_cnt = 0; out_ready = 0;
      #12;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_counters", int'(parity_err_cnt) + int'(frame_err_cnt) + int'(overrun_cnt), 0);
      chk("rst_out_data", int'(out_data), 0);
      @(negedge clk); rst = 1; chk_en = 1;

      // directed parity words
      step(1, 9'h155, 0, 1, 0, 2'd3, 0, 1);
      step(1, 9'h055, 0, 1, 0, 2'd3, 0, 1);
      step(1, 9'h041, 0, 1, 1, 2'd2, 0, 1);
      step(1, 9'h1FF, 0, 1, 1, 2'd0, 0, 1);
      step(1, 9'h1FF, 1, 0, 0, 2'd1, 0, 1);
      drain();
      chk("parity_cnt_directed", int'(parity_err_cnt), 3);

      // overflow with consumer stalled
      for (int i = 0; i < 5; i++) step(1, 9'(8'h10 + i), 0, 0, 0, 2'd3, 0, 0);
      chk("full_level", int'(fifo_level), 4);
      chk("full_overrun", int'(overrun), 1);
      chk("full_overrun_cnt", int'(overrun_cnt), 1);
      step(1, 9'h0A5, 0, 0, 0, 2'd3, 0, 1);
      chk("full_pushpop_level", int'(fifo_level), 4);
      chk("full_pushpop_ovcnt", int'(overrun_cnt), 1);
      drain();

      // counter saturation and clear with coincident event
      for (int i = 0; i < 300; i++) step(1, 9'h0AA, 1, 0, 0, 2'd3, 0, 1);
      idle(1);
      chk("frame_cnt_sat", int'(frame_err_cnt), MAXC);
      step(1, 9'h0AA, 1, 0, 0, 2'd3, 1, 1);
      chk("frame_cnt_clr_inc", int'(frame_err_cnt), 1);
      chk("overrun_clr", int'(overrun), 0);
      drain();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         rd = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom);
         step($urandom_range(0, 1) == 1, rd, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              2'($urandom_range(0, 3)), $urandom_range(0, 49) == 0,
              $urandom_range(0, 2) != 0);
      end
      drain();

`ifdef UART_CHK_BREAK_EN
      step(1, 9'h00B, 0, 0, 0, 2'd3, 0, 0);
      lvl_before = int'(fifo_level);
      step(1, 9'h000, 1, 1, 0, 2'($urandom_range(0, 3)), 0, 0);
      chk("break_pulse", int'(break_det), 1);
      chk("break_level", int'(fifo_level), lvl_before);
      idle(0);
      chk("break_pulse_end", int'(break_det), 0);
      drain();
`endif

      // asynchronous reset with words buffered
      for (int i = 0; i < 3; i++) step(1, 9'(8'h21 + i), 1, 1, 0, 2'd3, 0, 0);
      idle(0);
      chk("pre_rst_level", int'(fifo_level), 3);
      #2 rst = 0;
      #1;
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_level", int'(fifo_level), 0);
      chk("async_rst_cnts", int'(parity_err_cnt) + int'(frame_err_cnt) + int'(overrun_cnt), 0);
      @(negedge clk); rst = 1;
      for (int i = 0; i < 4; i++) idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
